mux_word_serializer: RTL

//  Serializes a WIDTH-bit parallel word into a 1-bit stream, one bit per accepted beat.
//  Bit selection uses a 2:1-mux tree driven by a bit-index counter.

---
 rtl/mux_word_serializer_pkg.sv | 20 ++
 rtl/mux_word_serializer_bit_select_mux.sv | 32 +++
 rtl/mux_word_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// the first/final bit positions for either serialization order.
package mux_word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit position emitted on the first beat of a word.
    function automatic int first_index(input int width, input bit msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Bit position emitted on the final beat of a word.
    function automatic int final_index(input int width, input bit msb_first);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage

// File: rtl/mux_word_serializer_bit_select_mux.sv
// WIDTH:1 bit selector built as a binary tree of 2:1 muxes. Level 0 holds the
// word zero-padded to the next power of two, so padded leaves read as 0; each
// following level halves the candidates using one select bit, LSB first.
module bit_select_mux #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             bit_out
);

    localparam int LEAVES = 1 << SEL_W;

    logic [LEAVES-1:0] leaves;

    assign leaves = LEAVES'(data);

    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        logic [(LEAVES >> l)-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = leaves;
        end else begin : g_mux
            for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_node
                assign v[j] = sel[l-1] ? g_lvl[l-1].v[2*j+1] : g_lvl[l-1].v[2*j];
            end
        end
    end

    assign bit_out = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/mux_word_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word, then emits one bit per
// accepted downstream beat along with a last flag and a running OR of the bits
// emitted so far. A new word can be taken on the final beat for gapless streams.
module mux_word_serializer
    import mux_word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_bit,
    output logic             down_last,
    output logic             down_or
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] START_IDX = IW'(first_index(WIDTH, MSB_FIRST));
    localparam logic [IW-1:0] END_IDX   = IW'(final_index(WIDTH, MSB_FIRST));

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              acc_q, acc_d;
    logic              sel_bit;
    logic              load;
    logic              beat;

    bit_select_mux #(
        .WIDTH (WIDTH),
        .SEL_W (IW)
    ) u_bit_select_mux (
        .data    (data_q),
        .sel     (idx_q),
        .bit_out (sel_bit)
    );

    // State register: FSM state, bit index, captured word and OR accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: load a word on accept, step the index on non-final beats,
    // and on the final beat either chain straight into the next word or go idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        acc_d   = acc_q;
        load    = up_valid && up_ready;
        beat    = down_valid && down_ready;
        if (load) begin
            state_d = SHIFT;
            data_d  = up_data;
            idx_d   = START_IDX;
            acc_d   = 1'b0;
        end else if (beat) begin
            if (down_last) begin
                state_d = IDLE;
                idx_d   = '0;
                acc_d   = 1'b0;
            end else begin
                acc_d = acc_q | sel_bit;
                idx_d = MSB_FIRST ? (idx_q - IW'(1)) : (idx_q + IW'(1));
            end
        end
    end

    // Output logic: serial outputs only while shifting; up_ready opens on the
    // final accepted beat so back-to-back words have no bubble.
    always_comb begin
        down_valid = 1'b0;
        down_bit   = 1'b0;
        down_last  = 1'b0;
        down_or    = 1'b0;
        if (state_q == SHIFT) begin
            down_valid = 1'b1;
            down_bit   = sel_bit;
            down_last  = (idx_q == END_IDX);
            down_or    = acc_q | sel_bit;
        end
        up_ready = rst_n && ((state_q == IDLE) || (down_last && down_ready));
    end

endmodule
